// File: rtl/channel_pulse_voice_pkg.sv
// Shared defaults and the duty-threshold helper for the pulse voice.
package channel_pulse_voice_pkg;

    localparam int unsigned PHASE_WIDTH_DEF  = 32;
    localparam int unsigned ENV_WIDTH_DEF    = 9;
    localparam int unsigned ENV_SHIFT_DEF    = 6;
    localparam int unsigned SAMPLE_WIDTH_DEF = 16;

    localparam logic [7:0] TOP_RESET = 8'hff;

    // Rounded half of top: 8'hff -> 128 (50%), 8'h3f -> 32, 8'h00 -> 0 (always low).
    function automatic logic [8:0] duty_thr(input logic [7:0] top);
        return ({1'b0, top} + 9'd1) >> 1;
    endfunction

endpackage

// File: rtl/channel_pulse_voice_accum.sv
// Phase accumulator with wrap carry and pulse-level compare; duty changes are
// held pending and only promoted at a phase wrap (or a stalled phase) to avoid glitches.
module pulse_phase_accumulator
    import channel_pulse_voice_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = PHASE_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_stb,
    input  logic [7:0]             i_top,
    input  logic                   i_top_valid,
    input  logic [PHASE_WIDTH-1:0] i_phase_delta,
    output logic                   o_level,
    output logic                   o_wrap
);

    if (PHASE_WIDTH < 9) begin : g_width_check
        $error("PHASE_WIDTH must be at least 9");
    end

    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [7:0]             active_q, active_d;
    logic [7:0]             pending_q, pending_d;
    logic                   dirty_q, dirty_d;
    logic                   level_q, level_d;
    logic                   wrap_q, wrap_d;
    logic [PHASE_WIDTH:0]   sum;
    logic                   promote;

    always_comb begin
        sum       = {1'b0, phase_q} + {1'b0, i_phase_delta};
        promote   = i_stb && dirty_q && (sum[PHASE_WIDTH] || (i_phase_delta == '0));
        phase_d   = phase_q;
        active_d  = active_q;
        pending_d = pending_q;
        dirty_d   = dirty_q;
        level_d   = level_q;
        wrap_d    = wrap_q;

        if (promote) begin
            active_d = pending_q;
            dirty_d  = 1'b0;
        end
        // A capture on the promotion edge re-arms dirty with the new value.
        if (i_top_valid) begin
            pending_d = i_top;
            dirty_d   = 1'b1;
        end
        if (i_stb) begin
            phase_d = sum[PHASE_WIDTH-1:0];
            wrap_d  = sum[PHASE_WIDTH];
            level_d = ({1'b0, sum[PHASE_WIDTH-1 -: 8]} < duty_thr(active_d));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_q   <= '0;
            active_q  <= TOP_RESET;
            pending_q <= '0;
            dirty_q   <= 1'b0;
            level_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            dirty_q   <= dirty_d;
            level_q   <= level_d;
            wrap_q    <= wrap_d;
        end
    end

    assign o_level = level_q;
    assign o_wrap  = wrap_q;

endmodule

// File: rtl/channel_pulse_voice.sv
// Pulse-wave voice: phase/level stage followed by a registered signed sample stage.
module channel_pulse_voice
    import channel_pulse_voice_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH  = PHASE_WIDTH_DEF,
    parameter int unsigned ENV_WIDTH    = ENV_WIDTH_DEF,
    parameter int unsigned ENV_SHIFT    = ENV_SHIFT_DEF,
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_sample_stb,
    input  logic [7:0]              i_top,
    input  logic                    i_top_valid,
    input  logic [PHASE_WIDTH-1:0]  i_phase_delta,
    input  logic [ENV_WIDTH-1:0]    i_envelope,
    output logic [SAMPLE_WIDTH-1:0] o_sample,
    output logic                    o_sample_valid,
    output logic                    o_cycle_stb
);

    if (SAMPLE_WIDTH < ENV_WIDTH + ENV_SHIFT + 1) begin : g_width_check
        $error("SAMPLE_WIDTH too narrow for ENV_WIDTH+ENV_SHIFT+1");
    end

    logic                    level;
    logic                    wrap;
    logic [ENV_WIDTH-1:0]    env_q, env_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    cyc_q, cyc_d;
    logic [SAMPLE_WIDTH-1:0] mag;

    pulse_phase_accumulator #(
        .PHASE_WIDTH (PHASE_WIDTH)
    ) u_accum (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stb         (i_sample_stb),
        .i_top         (i_top),
        .i_top_valid   (i_top_valid),
        .i_phase_delta (i_phase_delta),
        .o_level       (level),
        .o_wrap        (wrap)
    );

    always_comb begin
        env_d      = i_sample_stb ? i_envelope : env_q;
        s1_valid_d = i_sample_stb;
        mag        = SAMPLE_WIDTH'(env_q) << ENV_SHIFT;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        cyc_d      = 1'b0;
        if (s1_valid_q) begin
            sample_d = level ? mag : -mag;
            valid_d  = 1'b1;
            cyc_d    = wrap;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            env_q      <= '0;
            s1_valid_q <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            cyc_q      <= 1'b0;
        end else begin
            env_q      <= env_d;
            s1_valid_q <= s1_valid_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            cyc_q      <= cyc_d;
        end
    end

    assign o_sample       = sample_q;
    assign o_sample_valid = valid_q;
    assign o_cycle_stb    = cyc_q;

endmodule
